// File: rtl/id_stage_pipelined_if.sv
// id_stage_pipelined_if: instruction-in / decoded-bundle-out handshake and register-file write port
interface id_stage_pipelined_if #(parameter int DW = 32);
    logic          in_valid, in_ready, hazard, flush, wb_en, out_valid, out_ready;
    logic [31:0]   instr;
    logic [3:0]    sr, wb_dest;
    logic [DW-1:0] wb_data;
    logic          wb_en_o, mem_r_en, mem_w_en, b, s, imm, two_src;
    logic [3:0]    exe_cmd, dest, src1, src2;
    logic [DW-1:0] val_rn, val_rm;
    logic [11:0]   shift_operand;
    logic [23:0]   simm24;
    modport master (
        output in_valid, instr, hazard, flush, sr, wb_en, wb_dest, wb_data, out_ready,
        input  in_ready, out_valid, wb_en_o, mem_r_en, mem_w_en, b, s, imm, two_src,
               exe_cmd, dest, src1, src2, val_rn, val_rm, shift_operand, simm24
    );
    modport slave (
        input  in_valid, instr, hazard, flush, sr, wb_en, wb_dest, wb_data, out_ready,
        output in_ready, out_valid, wb_en_o, mem_r_en, mem_w_en, b, s, imm, two_src,
               exe_cmd, dest, src1, src2, val_rn, val_rm, shift_operand, simm24
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: ARM-style decode stage with register file, condition squash and EXE-side skid-free handshake
module id_stage_pipelined #(
    parameter int DW     = 32,
    parameter int NREG   = 16,
    parameter int BYPASS = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    id_stage_pipelined_if.slave bus
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [DW-1:0] rf [NREG];
    logic [1:0]    mode;
    logic [3:0]    opcode, alu, exe_d, rn_i, src2_d;
    logic          status, op_ok, is_cmp, dp, ld_st, is_str, cond_ok, acc, wr;
    logic          wb_d, mr_d, mw_d, b_d, s_d;
    logic [DW-1:0] rn_d, rm_d;

    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic z, cf, v, n;
        {z, cf, v, n} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return ~z;
            4'b0010: return cf;
            4'b0011: return ~cf;
            4'b0100: return n;
            4'b0101: return ~n;
            4'b0110: return v;
            4'b0111: return ~v;
            4'b1000: return cf & ~z;
            4'b1001: return ~cf | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return ~z & (n == v);
            4'b1101: return z | (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] alu_cmd(input logic [3:0] op);
        case (op)
            4'b1101: return 5'b1_0001;
            4'b1111: return 5'b1_1001;
            4'b0100: return 5'b1_0010;
            4'b0101: return 5'b1_0011;
            4'b0010: return 5'b1_0100;
            4'b0110: return 5'b1_0101;
            4'b0000: return 5'b1_0110;
            4'b1100: return 5'b1_0111;
            4'b0001: return 5'b1_1000;
            4'b1010: return 5'b1_0100;
            4'b1000: return 5'b1_0110;
            default: return 5'b0_0000;
        endcase
    endfunction

    assign mode     = bus.instr[27:26];
    assign opcode   = bus.instr[24:21];
    assign status   = bus.instr[20];
    assign rn_i     = bus.instr[19:16];
    assign {op_ok, alu} = alu_cmd(opcode);
    assign is_cmp   = (opcode == 4'b1010) || (opcode == 4'b1000);
    assign dp       = mode == 2'b00;
    assign ld_st    = mode == 2'b01;
    assign is_str   = ld_st & ~status;
    assign cond_ok  = cond_eval(bus.instr[31:28], bus.sr);
    assign exe_d    = !cond_ok ? 4'b0000 : dp ? alu : ld_st ? 4'b0010 : 4'b0000;
    assign wb_d     = cond_ok & ((dp & op_ok & ~is_cmp) | (ld_st & status));
    assign mr_d     = cond_ok & ld_st & status;
    assign mw_d     = cond_ok & is_str;
    assign b_d      = cond_ok & (mode == 2'b10);
    assign s_d      = cond_ok & dp & op_ok & status;
    assign src2_d   = is_str ? bus.instr[15:12] : bus.instr[3:0];

    // Write-back in the decode cycle can be forwarded so the operand is never stale
    assign wr   = bus.wb_en && (32'(bus.wb_dest) < NREG);
    assign rn_d = (BYPASS != 0 && wr && bus.wb_dest == rn_i) ? bus.wb_data :
                  (32'(rn_i) < NREG) ? rf[rn_i[IW-1:0]] : '0;
    assign rm_d = (BYPASS != 0 && wr && bus.wb_dest == src2_d) ? bus.wb_data :
                  (32'(src2_d) < NREG) ? rf[src2_d[IW-1:0]] : '0;

    assign bus.in_ready = ~bus.hazard & ~bus.flush & (~bus.out_valid | bus.out_ready);
    assign acc          = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wr) begin
            rf[bus.wb_dest[IW-1:0]] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.wb_en_o       <= 1'b0;
            bus.mem_r_en      <= 1'b0;
            bus.mem_w_en      <= 1'b0;
            bus.b             <= 1'b0;
            bus.s             <= 1'b0;
            bus.exe_cmd       <= '0;
            bus.val_rn        <= '0;
            bus.val_rm        <= '0;
            bus.imm           <= 1'b0;
            bus.shift_operand <= '0;
            bus.simm24        <= '0;
            bus.dest          <= '0;
            bus.src1          <= '0;
            bus.src2          <= '0;
            bus.two_src       <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (acc) begin
            bus.out_valid     <= 1'b1;
            bus.wb_en_o       <= wb_d;
            bus.mem_r_en      <= mr_d;
            bus.mem_w_en      <= mw_d;
            bus.b             <= b_d;
            bus.s             <= s_d;
            bus.exe_cmd       <= exe_d;
            bus.val_rn        <= rn_d;
            bus.val_rm        <= rm_d;
            bus.imm           <= bus.instr[25];
            bus.shift_operand <= bus.instr[11:0];
            bus.simm24        <= bus.instr[23:0];
            bus.dest          <= bus.instr[15:12];
            bus.src1          <= rn_i;
            bus.src2          <= src2_d;
            bus.two_src       <= ~bus.instr[25] | is_str;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed decode vectors with a queue scoreboard checked on every output transfer
module tb_id_stage_pipelined;
    typedef struct packed {
        logic [4:0]  ctl;
        logic [3:0]  exe;
        logic [31:0] rn, rm;
        logic        imm;
        logic [11:0] sh;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2;
        logic        two;
    } exp_t;

    logic clk, rst_n;
    int   n_cmp = 0, n_bad = 0;
    exp_t sb[$];
    exp_t x;

    id_stage_pipelined_if #(.DW(32)) bus();
    id_stage_pipelined #(.DW(32), .NREG(16), .BYPASS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] i, input logic [3:0] exe, input logic [4:0] ctl,
                                input logic [31:0] rn, input logic [31:0] rm, input logic [3:0] s2, input logic two);
        return {ctl, exe, rn, rm, i[25], i[11:0], i[23:0], i[15:12], i[19:16], s2, two};
    endfunction

    function automatic exp_t cur();
        return {bus.wb_en_o, bus.mem_r_en, bus.mem_w_en, bus.b, bus.s, bus.exe_cmd, bus.val_rn, bus.val_rm,
                bus.imm, bus.shift_operand, bus.simm24, bus.dest, bus.src1, bus.src2, bus.two_src};
    endfunction

    task automatic check(input string nm, input exp_t a, input exp_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk1(input string nm, input logic a, input logic e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input exp_t e);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        sb.push_back(e);
        @(negedge clk) chk1("in_ready", bus.in_ready, 1'b1);
        @(posedge clk) #1 bus.in_valid = 1'b0;
        @(negedge clk) chk1("latency_valid", bus.out_valid, 1'b1);
        @(posedge clk) #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %h expected nothing", cur());
            end else begin
                check("decode_out", cur(), sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        bus.in_valid = 0; bus.instr = '0; bus.hazard = 0; bus.flush = 0; bus.sr = '0;
        bus.wb_en = 0; bus.wb_dest = '0; bus.wb_data = '0; bus.out_ready = 1;
        #3;
        check("reset_out", cur(), '0);
        chk1("reset_valid", bus.out_valid, 1'b0);
        chk1("reset_ready", bus.in_ready, 1'b1);
        @(posedge clk) #1 rst_n = 1;
        bus.wb_en = 1; bus.wb_dest = 4'd1; bus.wb_data = 32'd5;
        @(posedge clk) #1 bus.wb_dest = 4'd2; bus.wb_data = 32'd7;
        @(posedge clk) #1 bus.wb_en = 0;

        issue(32'hE0813002, mk(32'hE0813002, 4'b0010, 5'b10000, 32'd5, 32'd7, 4'd2, 1'b1));
        bus.wb_en = 1; bus.wb_dest = 4'd1; bus.wb_data = 32'h55;
        issue(32'hE0813002, mk(32'hE0813002, 4'b0010, 5'b10000, 32'h55, 32'd7, 4'd2, 1'b1));
        bus.wb_en = 0;

        issue(32'h0A000010, mk(32'h0A000010, 4'b0000, 5'b00000, 32'd0, 32'd0, 4'd0, 1'b0));
        bus.sr = 4'b1000;
        issue(32'h0A000010, mk(32'h0A000010, 4'b0000, 5'b00010, 32'd0, 32'd0, 4'd0, 1'b0));
        issue(32'h10813002, mk(32'h10813002, 4'b0000, 5'b00000, 32'h55, 32'd7, 4'd2, 1'b1));
        bus.sr = 4'b0010;
        issue(32'hA0813002, mk(32'hA0813002, 4'b0000, 5'b00000, 32'h55, 32'd7, 4'd2, 1'b1));
        bus.sr = 4'b0000;
        issue(32'hC0813002, mk(32'hC0813002, 4'b0010, 5'b10000, 32'h55, 32'd7, 4'd2, 1'b1));

        issue(32'hE5814008, mk(32'hE5814008, 4'b0010, 5'b00100, 32'h55, 32'd0, 4'd4, 1'b1));
        issue(32'hE5914008, mk(32'hE5914008, 4'b0010, 5'b11000, 32'h55, 32'd0, 4'd8, 1'b1));
        issue(32'hE1510002, mk(32'hE1510002, 4'b0100, 5'b00001, 32'h55, 32'd7, 4'd2, 1'b1));
        issue(32'hE3A0300A, mk(32'hE3A0300A, 4'b0001, 5'b10000, 32'd0, 32'd0, 4'd10, 1'b0));
        issue(32'hE0613002, mk(32'hE0613002, 4'b0000, 5'b00000, 32'h55, 32'd7, 4'd2, 1'b1));
        issue(32'hE0513002, mk(32'hE0513002, 4'b0100, 5'b10001, 32'h55, 32'd7, 4'd2, 1'b1));

        // Back-pressure: A held for three cycles while B waits
        bus.out_ready = 0;
        x = mk(32'hE0813002, 4'b0010, 5'b10000, 32'h55, 32'd7, 4'd2, 1'b1);
        issue(32'hE0813002, x);
        bus.in_valid = 1; bus.instr = 32'hE0613002;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("stall_ready", bus.in_ready, 1'b0);
            check("stall_hold", cur(), x);
            @(posedge clk) #1;
        end
        bus.out_ready = 1;
        sb.push_back(mk(32'hE0613002, 4'b0000, 5'b00000, 32'h55, 32'd7, 4'd2, 1'b1));
        @(posedge clk) #1 bus.in_valid = 0;
        @(negedge clk) chk1("stall_release_valid", bus.out_valid, 1'b1);
        @(posedge clk) #1;

        bus.hazard = 1; bus.in_valid = 1; bus.instr = 32'hE1510002;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("hazard_ready", bus.in_ready, 1'b0);
            chk1("hazard_bubble", bus.out_valid, 1'b0);
            @(posedge clk) #1;
        end
        bus.hazard = 0;
        issue(32'hE1510002, mk(32'hE1510002, 4'b0100, 5'b00001, 32'h55, 32'd7, 4'd2, 1'b1));

        bus.out_ready = 0;
        x = mk(32'hE0513002, 4'b0100, 5'b10001, 32'h55, 32'd7, 4'd2, 1'b1);
        issue(32'hE0513002, x);
        bus.flush = 1; bus.hazard = 1; bus.in_valid = 1; bus.instr = 32'hE3A0300A;
        @(negedge clk) chk1("flush_ready", bus.in_ready, 1'b0);
        @(posedge clk) #1 bus.flush = 0; bus.hazard = 0; bus.in_valid = 0;
        @(negedge clk);
        chk1("flush_valid", bus.out_valid, 1'b0);
        check("flush_no_capture", cur(), x);
        void'(sb.pop_front());
        bus.out_ready = 1;
        @(posedge clk) #1;

        bus.out_ready = 0;
        issue(32'hE5814008, mk(32'hE5814008, 4'b0010, 5'b00100, 32'h55, 32'd0, 4'd4, 1'b1));
        #1 rst_n = 0;
        #1;
        chk1("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_out", cur(), '0);
        sb.delete();
        @(posedge clk) #1 rst_n = 1; bus.out_ready = 1;
        issue(32'hE0813002, mk(32'hE0813002, 4'b0010, 5'b10000, 32'd0, 32'd0, 4'd2, 1'b1));

        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage_pipelined.md
ID_STAGE_PIPELINED -- requirements
Module: id_stage_pipelined

Interface
REQ-001 Parameter DW, default 32, register-file and operand data width (16..64).
REQ-002 Parameter NREG, default 16, number of architectural registers; register index is 4 bits, indices >= NREG read as zero.
REQ-003 Parameter BYPASS, default 1, enables same-cycle write-back-to-read forwarding.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid in 1 / in_ready out 1  instruction handshake from IF register.
REQ-007 instr  in  32  ARM-format instruction word.
REQ-008 hazard  in  1  hazard-unit stall request; flush  in  1  branch-taken squash.
REQ-009 sr  in  4  status flags {z,c,v,n} = sr[3:0].
REQ-010 wb_en in 1, wb_dest in 4, wb_data in DW  register-file write port.
REQ-011 out_valid out 1 / out_ready in 1  handshake to EXE register.
REQ-012 Registered outputs: wb_en_o, mem_r_en, mem_w_en, b, s (1 each); exe_cmd 4; val_rn, val_rm DW; imm 1; shift_operand 12; simm24 24; dest 4; src1, src2 4; two_src 1.

Function
REQ-013 Fields: cond=[31:28], mode=[27:26], imm=[25], opcode=[24:21], status=[20], Rn=[19:16], Rd=[15:12], shift_operand=[11:0], Rm=[3:0], simm24=[23:0].
REQ-014 exe_cmd (mode 00): MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; other opcodes -> all controls 0.
REQ-015 Mode 00: wb_en_o=1 except CMP/TST; s=status. Mode 01: exe_cmd=0010; status=1 -> LDR (mem_r_en, wb_en_o); status=0 -> STR (mem_w_en). Mode 10: b=1, others 0. Mode 11: all controls 0.
REQ-016 Condition: EQ z, NE ~z, CS c, CC ~c, MI n, PL ~n, VS v, VC ~v, HI c&~z, LS ~c|z, GE n==v, LT n!=v, GT ~z&(n==v), LE z|(n!=v), AL 1, 1111 0.
REQ-017 Condition false -> wb_en_o, mem_r_en, mem_w_en, b, s, exe_cmd captured as 0; remaining fields captured unchanged; out_valid still asserted.
REQ-018 src1=Rn; src2=Rd when STR else Rm; two_src = ~imm | STR.
REQ-019 Register file NREG x DW; write when wb_en at rising edge, wb_dest < NREG.
REQ-020 Reads combinational on src1/src2; BYPASS=1 and wb_en and wb_dest==src -> read returns wb_data same cycle; BYPASS=0 -> old value.
REQ-021 in_ready = ~hazard & ~flush & (~out_valid | out_ready).
REQ-022 Accept (in_valid & in_ready): capture all decoded outputs and operands, out_valid<=1 next edge; latency 1 cycle.
REQ-023 out_valid & ~out_ready: all outputs held bit-stable, no capture.
REQ-024 out_ready & no accept (including hazard): out_valid<=0 (bubble); controls and data hold last values.
REQ-025 flush: out_valid<=0 next edge, no capture, regardless of out_ready or in_valid; flush dominates hazard.
REQ-026 Register-file write proceeds independent of hazard, flush and stall.

Reset
REQ-027 rst low: immediately out_valid=0, all registered outputs 0, all NREG registers 0; in_ready follows REQ-021.
REQ-028 Reset mid-stall discards held instruction; first accept after rst release yields out_valid one cycle later.

Verification
REQ-029 R1=5,R2=7 preload; ADD R3,R1,R2 (0xE0813002), out_ready=1 -> next cycle out_valid=1, exe_cmd=0010, wb_en_o=1, val_rn=5, val_rm=7, dest=3, two_src=1.
REQ-030 wb_en=1, wb_dest=1, wb_data=0x55 same cycle as decode of Rn=R1 -> val_rn=0x55 (BYPASS=1), old value (BYPASS=0).
REQ-031 BEQ with sr=0000 -> out_valid=1, b=0, all controls 0; with sr=1000 -> b=1, simm24=instr[23:0].
REQ-032 out_ready=0 three cycles after accept, new in_valid -> in_ready=0, outputs stable; out_ready=1 -> next instruction captured following cycle.
REQ-033 hazard=1 two cycles, out_ready=1 -> two bubbles (out_valid=0), instr not consumed; flush with hazard -> out_valid=0, no capture.
REQ-034 STR R4,[R1,#8] (0xE5814008) -> mem_w_en=1, src2=4, two_src=1, wb_en_o=0; async rst low mid-cycle -> outputs 0 before next edge.
